// File: rtl/axa_pkg.sv
// Shared definitions for the undo stack: default geometry, FSM encoding and
// the pointer/count width helper.
package axa_pkg;

  localparam int AXA_DEF_WIDTH = 16;
  localparam int AXA_DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2,
    ST_ERR     = 2'd3
  } axa_state_e;

  // Pointer width for a power-of-two depth; count is one bit wider.
  function automatic int axa_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/axa_ustack_ram.sv
// Entry storage for the undo stack: DEPTH x WIDTH, one synchronous write port
// and one combinational read port. Contents are deliberately not reset.
module axa_ustack_ram
  import axa_pkg::*;
#(
  parameter int WIDTH = AXA_DEF_WIDTH,
  parameter int DEPTH = AXA_DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [axa_aw(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]          wdata,
  input  logic [axa_aw(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]          rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/axa_undo_stack.sv
// LIFO undo stack with sticky overflow/underflow flags and a status FSM.
// Build option AXA_USTACK_OVF_TRAP_EN: a push into a full stack is rejected and
// traps in ERR until flush; otherwise it overwrites the oldest entry.
module axa_undo_stack
  import axa_pkg::*;
#(
  parameter int WIDTH = AXA_DEF_WIDTH,
  parameter int DEPTH = AXA_DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_en,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop_en,
  input  logic                    flush,
  output logic                    push_ready,
  output logic                    pop_valid,
  output logic [WIDTH-1:0]        pop_data,
  output logic [axa_aw(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full,
  output logic                    ovf,
  output logic                    unf,
  output logic [1:0]              state
);

  localparam int         AW       = axa_aw(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW-1:0]  sp_r, sp_s;
  logic [AW:0]    count_r, count_s;
  logic           pop_valid_r, pop_valid_s;
  logic [WIDTH-1:0] pop_data_r, pop_data_s;
  logic           ovf_r, ovf_s;
  logic           unf_r, unf_s;
  logic           empty_r, empty_s;
  logic           full_r, full_s;
  logic           err_s;
  axa_state_e     state_r, state_s;

  logic           we_s;
  logic [AW-1:0]  waddr_s;
  logic [AW-1:0]  top_addr_s;
  logic [WIDTH-1:0] rdata_s;

  assign top_addr_s = sp_r - 1'b1;

  axa_ustack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (push_data),
    .raddr (top_addr_s),
    .rdata (rdata_s)
  );

  // Next-state, memory write control and status derivation.
  always_comb begin
    sp_s        = sp_r;
    count_s     = count_r;
    pop_valid_s = 1'b0;
    pop_data_s  = pop_data_r;
    ovf_s       = ovf_r;
    unf_s       = unf_r;
    err_s       = (state_r == ST_ERR);
    we_s        = 1'b0;
    waddr_s     = sp_r;

    if (flush) begin
      sp_s    = '0;
      count_s = '0;
      ovf_s   = 1'b0;
      unf_s   = 1'b0;
      err_s   = 1'b0;
    end else if (err_s) begin
      // Trapped: everything but flush is ignored.
      we_s = 1'b0;
    end else begin
      case ({push_en, pop_en})
        2'b10: begin
          if (!full_r) begin
            we_s    = 1'b1;
            sp_s    = sp_r + 1'b1;
            count_s = count_r + 1'b1;
          end else begin
            ovf_s = 1'b1;
`ifdef AXA_USTACK_OVF_TRAP_EN
            err_s = 1'b1;
`else
            // sp already addresses the oldest entry when full.
            we_s  = 1'b1;
            sp_s  = sp_r + 1'b1;
`endif
          end
        end
        2'b01: begin
          if (!empty_r) begin
            pop_data_s  = rdata_s;
            pop_valid_s = 1'b1;
            sp_s        = top_addr_s;
            count_s     = count_r - 1'b1;
          end else begin
            unf_s = 1'b1;
          end
        end
        2'b11: begin
          pop_valid_s = 1'b1;
          if (!empty_r) begin
            pop_data_s = rdata_s;
            we_s       = 1'b1;
            waddr_s    = top_addr_s;
          end else begin
            pop_data_s = push_data;
          end
        end
        default: begin
          we_s = 1'b0;
        end
      endcase
    end

    empty_s = (count_s == '0);
    full_s  = (count_s == CNT_FULL);
    if (err_s) begin
      state_s = ST_ERR;
    end else if (empty_s) begin
      state_s = ST_EMPTY;
    end else if (full_s) begin
      state_s = ST_FULL;
    end else begin
      state_s = ST_PARTIAL;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_r        <= '0;
      count_r     <= '0;
      pop_valid_r <= 1'b0;
      pop_data_r  <= '0;
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      state_r     <= ST_EMPTY;
    end else begin
      sp_r        <= sp_s;
      count_r     <= count_s;
      pop_valid_r <= pop_valid_s;
      pop_data_r  <= pop_data_s;
      ovf_r       <= ovf_s;
      unf_r       <= unf_s;
      empty_r     <= empty_s;
      full_r      <= full_s;
      state_r     <= state_s;
    end
  end

`ifdef AXA_USTACK_OVF_TRAP_EN
  assign push_ready = (state_r != ST_ERR) && (!full_r || pop_en);
`else
  assign push_ready = 1'b1;
`endif

  assign pop_valid = pop_valid_r;
  assign pop_data  = pop_data_r;
  assign count     = count_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign ovf       = ovf_r;
  assign unf       = unf_r;
  assign state     = state_r;

endmodule

// File: tb/tb_axa_undo_stack.sv
// Self-checking bench for axa_undo_stack (DEPTH=4): directed scenarios plus
// random traffic against a queue-based reference model.
module tb_axa_undo_stack;

  localparam int W = 16;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          push_en = 1'b0;
  logic [W-1:0]  push_data = '0;
  logic          pop_en = 1'b0;
  logic          flush = 1'b0;
  logic          push_ready;
  logic          pop_valid;
  logic [W-1:0]  pop_data;
  logic [2:0]    count;
  logic          empty, full, ovf, unf;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: stack as a queue, newest entry at the back.
  logic [W-1:0] mq[$];
  logic         m_ovf = 1'b0, m_unf = 1'b0, m_err = 1'b0, m_pv = 1'b0;
  logic [W-1:0] m_pd = '0;

  axa_undo_stack #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .push_en    (push_en),
    .push_data  (push_data),
    .pop_en     (pop_en),
    .flush      (flush),
    .push_ready (push_ready),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .ovf        (ovf),
    .unf        (unf),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_ready(input logic pop);
`ifdef AXA_USTACK_OVF_TRAP_EN
    return !m_err && (mq.size() < D || pop);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step(input logic p, input logic [W-1:0] d, input logic o, input logic f);
    m_pv = 1'b0;
    if (f) begin
      mq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0;
    end else if (!m_err) begin
      if (p && !o) begin
        if (mq.size() < D) begin
          mq.push_back(d);
        end else begin
          m_ovf = 1'b1;
`ifdef AXA_USTACK_OVF_TRAP_EN
          m_err = 1'b1;
`else
          void'(mq.pop_front());
          mq.push_back(d);
`endif
        end
      end else if (o && !p) begin
        if (mq.size() > 0) begin
          m_pd = mq.pop_back();
          m_pv = 1'b1;
        end else begin
          m_unf = 1'b1;
        end
      end else if (o && p) begin
        m_pv = 1'b1;
        if (mq.size() > 0) begin
          m_pd = mq[$];
          mq[$] = d;
        end else begin
          m_pd = d;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [1:0] es;
    es = m_err ? 2'd3 : (mq.size() == 0) ? 2'd0 : (mq.size() == D) ? 2'd2 : 2'd1;
    chk_val("pop_valid", pop_valid, m_pv);
    chk_val("pop_data", pop_data, m_pd);
    chk_val("count", count, mq.size());
    chk_val("empty", empty, mq.size() == 0);
    chk_val("full", full, mq.size() == D);
    chk_val("ovf", ovf, m_ovf);
    chk_val("unf", unf, m_unf);
    chk_val("state", state, es);
  endtask

  // One clock of stimulus: drive, check push_ready, advance model, check outputs.
  task automatic step(input logic p, input logic [W-1:0] d, input logic o, input logic f);
    push_en = p; push_data = d; pop_en = o; flush = f;
    #1;
    chk_val("push_ready", push_ready, exp_ready(o));
    model_step(p, d, o, f);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    push_en = 1'b0; pop_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    #12;
    chk_val("rst_count", count, 3'd0);
    chk_val("rst_pop_valid", pop_valid, 1'b0);
    chk_val("rst_pop_data", pop_data, 16'h0000);
    chk_val("rst_empty", empty, 1'b1);
    chk_val("rst_state", state, 2'd0);
    chk_val("rst_push_ready", push_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;

    // LIFO order with one-cycle pop latency.
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h3333, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk_val("lifo_pop1", pop_data, 16'h3333);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk_val("lifo_pop2", pop_data, 16'h2222);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk_val("lifo_pop3", pop_data, 16'h1111);
    chk_val("lifo_empty", empty, 1'b1);

    // Underflow is sticky until flush.
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk_val("unf_pv", pop_valid, 1'b0);
    chk_val("unf_set", unf, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_val("unf_clr", unf, 1'b0);

    // Simultaneous push/pop replaces the top.
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'hAAAA, 1'b1, 1'b0);
    chk_val("swap_data", pop_data, 16'h2222);
    chk_val("swap_count", count, 3'd2);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk_val("swap_next", pop_data, 16'hAAAA);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Push/pop together on empty forwards the data.
    step(1'b1, 16'h5A5A, 1'b1, 1'b0);
    chk_val("fwd_data", pop_data, 16'h5A5A);
    chk_val("fwd_unf", unf, 1'b0);

    // Overflow behaviour at DEPTH=4.
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    chk_val("ovf_flag", ovf, 1'b1);
    chk_val("ovf_count", count, 3'd4);
`ifdef AXA_USTACK_OVF_TRAP_EN
    chk_val("trap_state", state, 2'd3);
    idle(); #1;
    chk_val("trap_ready", push_ready, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk_val("trap_pop_ign", pop_valid, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    chk_val("trap_flush_st", state, 2'd0);
    idle(); #1;
    chk_val("trap_flush_rdy", push_ready, 1'b1);
`else
    chk_val("ovf_full", full, 1'b1);
    for (int i = 5; i >= 2; i--) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      chk_val("ovf_pop", pop_data, 16'(i));
    end
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset during a pop response.
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b1, 16'h7777, 1'b0, 1'b0);
    step(1'b1, 16'h8888, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk_val("arst_pre_pv", pop_valid, 1'b1);
    idle();
    reset = 1'b0;
    #1;
    chk_val("arst_pv", pop_valid, 1'b0);
    chk_val("arst_count", count, 3'd0);
    chk_val("arst_empty", empty, 1'b1);
    reset = 1'b1;
    mq.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_err = 1'b0; m_pv = 1'b0; m_pd = '0;
    step(1'b1, 16'h4242, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk_val("arst_after", pop_data, 16'h4242);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
